// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the latency-modelled data memory:
//     - mem_state_e : controller states (INIT sweep, IDLE, WAIT, RESP)
//     - LANE_W      : width of one byte-enable lane (the merge granularity)
//     - CNT_W       : width of the latency counter (covers LATENCY up to 15)
//     - wait_load() : value loaded into the latency counter at accept time
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int LANE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  // WAIT spans LATENCY-1 cycles and the counter reports done on the cycle
  // it reads zero, so the load value is two less than the latency.
  function automatic logic [CNT_W-1:0] wait_load(input int latency);
    return (latency > 1) ? CNT_W'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
//   Down-counter used to time the WAIT phase of a request.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous, active-high, clears the count
//     load       in   load load_value (takes priority over count)
//     load_value in   CNT_W-bit start value
//     count      in   decrement by one while nonzero
//     done       out  count has reached zero
// ---------------------------------------------------------------------------
module lat_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             count,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/data_mem_lat.sv
// ---------------------------------------------------------------------------
// data_mem_lat
//   Word-organised data memory with byte-lane writes and a fixed, parameter-
//   selected response latency. After reset the whole array is swept to zero
//   one word per cycle before requests are taken.
//
//   Parameters:
//     DATA_W     data word width (multiple of 8)
//     DEPTH_LOG2 log2 of the number of words
//     LATENCY    cycles from accept edge to response cycle, 1..15
//     BASE_ADDR  byte address of word 0
//
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   synchronous, active-high
//     req_valid    in   request present
//     req_ready    out  request accepted at the next edge if req_valid
//     req_addr     in   32-bit byte address
//     req_byteen   in   lane enables, zero = read, nonzero = write
//     req_wdata    in   lane-aligned write data
//     resp_valid   out  one-cycle response pulse
//     resp_rdata   out  read word (0 for writes and errors)
//     resp_err     out  request rejected (range or alignment)
//     trace_valid  out  one-cycle pulse after each committed write
//     trace_addr   out  word-aligned byte address of the committed write
//     trace_data   out  full word after the lane merge
// ---------------------------------------------------------------------------
module data_mem_lat
  import mem_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W/8-1:0]    req_byteen,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   trace_valid,
  output logic [31:0]            trace_addr,
  output logic [DATA_W-1:0]      trace_data
);

  localparam int                    BYTES      = DATA_W / LANE_W;
  localparam int                    BYTE_SHIFT = $clog2(BYTES);
  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [32:0]           SPAN       = 33'(1) << (DEPTH_LOG2 + BYTE_SHIFT);
  localparam logic [31:0]           ALIGN_MASK = 32'(BYTES - 1);
  localparam logic [DEPTH_LOG2-1:0] INIT_LAST  = '1;
  localparam logic [CNT_W-1:0]      LOAD_VAL   = wait_load(LATENCY);

  mem_state_e              state;
  logic [DEPTH_LOG2-1:0]   init_idx;
  logic [DATA_W-1:0]       mem [0:DEPTH-1];

  logic                    ready_q;
  logic                    valid_q;
  logic                    err_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    tvalid_q;
  logic [31:0]             taddr_q;
  logic [DATA_W-1:0]       tdata_q;

  logic                    pend_err;
  logic [DATA_W-1:0]       pend_rdata;

  logic                    accept;
  logic                    is_write;
  logic                    req_err;
  logic                    commit;
  logic [32:0]             offset;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic [DATA_W-1:0]       rd_word;
  logic [DATA_W-1:0]       merged;
  logic [DATA_W-1:0]       acc_rdata;
  logic                    cnt_done;

  // Outputs are registered but masked by reset so that nothing is visible
  // while reset is held, even in the cycle before the first reset edge.
  // Masking req_ready also keeps any request from being accepted then.
  assign req_ready   = ready_q  & ~reset;
  assign resp_valid  = valid_q  & ~reset;
  assign resp_err    = err_q    & ~reset;
  assign resp_rdata  = reset ? '0 : rdata_q;
  assign trace_valid = tvalid_q & ~reset;
  assign trace_addr  = reset ? '0 : taddr_q;
  assign trace_data  = reset ? '0 : tdata_q;

  // Request decode. The offset is computed one bit wider than the address so
  // that addresses below BASE_ADDR wrap to a huge value and fail the range
  // compare together with addresses past the end of the array.
  always_comb begin
    accept   = req_valid & req_ready;
    is_write = |req_byteen;
    offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    req_err  = (offset >= SPAN) | ((req_addr & ALIGN_MASK) != 32'd0);
    word_idx = offset[BYTE_SHIFT +: DEPTH_LOG2];
    rd_word  = mem[word_idx];
    commit   = accept & is_write & ~req_err;
  end

  // Lane merge: enabled lanes take the write data, the rest keep the stored
  // word. The merged word is both written back and published on the trace.
  always_comb begin
    merged = rd_word;
    for (int l = 0; l < BYTES; l++) begin
      if (req_byteen[l]) begin
        merged[l*LANE_W +: LANE_W] = req_wdata[l*LANE_W +: LANE_W];
      end
    end
    acc_rdata = (req_err || is_write) ? '0 : rd_word;
  end

  // Storage: the INIT sweep clears one word per cycle; afterwards only
  // committed (in-range, aligned) writes touch the array.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_idx] <= '0;
    end else if (commit) begin
      mem[word_idx] <= merged;
    end
  end

  lat_counter u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept && (LATENCY > 1)),
    .load_value (LOAD_VAL),
    .count      (state == WAIT),
    .done       (cnt_done)
  );

  // Controller. The response of a request is captured at its accept edge
  // (pend_*) so later input changes cannot disturb it. Accepts are taken in
  // both IDLE and RESP, giving back-to-back operation without a bubble.
  // Trace pulses are driven straight from the commit, independent of the
  // response timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      init_idx   <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      pend_err   <= 1'b0;
      pend_rdata <= '0;
      tvalid_q   <= 1'b0;
      taddr_q    <= '0;
      tdata_q    <= '0;
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      tvalid_q <= 1'b0;

      if (commit) begin
        tvalid_q <= 1'b1;
        taddr_q  <= req_addr & ~ALIGN_MASK;
        tdata_q  <= merged;
      end

      unique case (state)
        INIT: begin
          if (init_idx == INIT_LAST) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            init_idx <= init_idx + DEPTH_LOG2'(1);
          end
        end

        IDLE, RESP: begin
          if (accept) begin
            pend_err   <= req_err;
            pend_rdata <= acc_rdata;
            if (LATENCY == 1) begin
              state   <= RESP;
              ready_q <= 1'b1;
              valid_q <= 1'b1;
              err_q   <= req_err;
              rdata_q <= acc_rdata;
            end else begin
              state   <= WAIT;
              ready_q <= 1'b0;
            end
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end

        WAIT: begin
          if (cnt_done) begin
            state   <= RESP;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
            err_q   <= pend_err;
            rdata_q <= pend_rdata;
          end
        end

        default: begin
          state    <= INIT;
          init_idx <= '0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lat.sv
// ---------------------------------------------------------------------------
// tb_data_mem_lat
//   Self-checking bench for data_mem_lat. The main instance uses default
//   parameters; two small instances (LATENCY 1 and 15) share one request
//   port to confirm the latency parameter end to end.
// ---------------------------------------------------------------------------
module tb_data_mem_lat;

  logic        clk;
  logic        reset;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  logic        alt_valid;
  logic [31:0] alt_addr;
  logic [3:0]  alt_byteen;
  logic [31:0] alt_wdata;

  logic        a1_ready, a1_rvalid, a1_err, a1_tvalid;
  logic [31:0] a1_rdata, a1_taddr, a1_tdata;
  logic        a15_ready, a15_rvalid, a15_err, a15_tvalid;
  logic [31:0] a15_rdata, a15_taddr, a15_tdata;

  int checks;
  int errors;

  data_mem_lat dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data)
  );

  data_mem_lat #(.DATA_W(32), .DEPTH_LOG2(4), .LATENCY(1), .BASE_ADDR(32'h0)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(alt_valid), .req_ready(a1_ready), .req_addr(alt_addr),
    .req_byteen(alt_byteen), .req_wdata(alt_wdata),
    .resp_valid(a1_rvalid), .resp_rdata(a1_rdata), .resp_err(a1_err),
    .trace_valid(a1_tvalid), .trace_addr(a1_taddr), .trace_data(a1_tdata)
  );

  data_mem_lat #(.DATA_W(32), .DEPTH_LOG2(4), .LATENCY(15), .BASE_ADDR(32'h0)) dut_l15 (
    .clk(clk), .reset(reset),
    .req_valid(alt_valid), .req_ready(a15_ready), .req_addr(alt_addr),
    .req_byteen(alt_byteen), .req_wdata(alt_wdata),
    .resp_valid(a15_rvalid), .resp_rdata(a15_rdata), .resp_err(a15_err),
    .trace_valid(a15_tvalid), .trace_addr(a15_taddr), .trace_data(a15_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_trace;
    logic [31:0] exp_taddr;
    logic [31:0] exp_tdata;
  } vec_t;

  vec_t vecs[14];

  // Advance to just after the next rising edge; all checks and input
  // changes happen at this point, away from the edge itself.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Counts cycles from now until req_ready rises (bounded), and notes any
  // response pulse seen while waiting.
  task automatic countReadyLow(output int n, output logic saw_resp);
    n = 0;
    saw_resp = 1'b0;
    while (!req_ready && n < 5000) begin
      if (resp_valid) saw_resp = 1'b1;
      n++;
      step();
    end
  endtask

  // Issues one request on the main instance and follows it to its response.
  // While idle the other request fields carry junk that must be ignored.
  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd, output int lat,
                               output logic err, output logic [31:0] rd,
                               output logic tv, output logic [31:0] ta,
                               output logic [31:0] td);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    req_valid  = 1'b1;
    req_addr   = a;
    req_byteen = be;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
    req_addr   = 32'h0000_0010;
    req_byteen = 4'hF;
    req_wdata  = 32'hFFFF_FFFF;
    tv = trace_valid;
    ta = trace_addr;
    td = trace_data;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    err = resp_err;
    rd  = resp_rdata;
  endtask

  initial begin
    int          lat;
    int          n;
    int          lat1;
    int          lat15;
    logic        err;
    logic        tv;
    logic        saw;
    logic [31:0] rd;
    logic [31:0] ta;
    logic [31:0] td;
    logic [31:0] rd1;
    logic [31:0] rd15;

    checks = 0;
    errors = 0;

    //        addr          be     wdata          err   rdata          trace taddr          tdata
    vecs[0]  = '{32'h0000_0010, 4'b0000, 32'h0,          1'b0, 32'h0000_0000, 1'b0, 32'h0,          32'h0};
    vecs[1]  = '{32'h0000_0010, 4'b0011, 32'hAABB_CCDD,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010, 32'h0000_CCDD};
    vecs[2]  = '{32'h0000_0010, 4'b0000, 32'h0,          1'b0, 32'h0000_CCDD, 1'b0, 32'h0,          32'h0};
    vecs[3]  = '{32'h0000_0010, 4'b1100, 32'h1122_3344,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010, 32'h1122_CCDD};
    vecs[4]  = '{32'h0000_0010, 4'b0000, 32'h0,          1'b0, 32'h1122_CCDD, 1'b0, 32'h0,          32'h0};
    vecs[5]  = '{32'h0000_4000, 4'b0000, 32'h0,          1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0};
    vecs[6]  = '{32'h0000_0012, 4'b0000, 32'h0,          1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0};
    vecs[7]  = '{32'h0000_0012, 4'b1111, 32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0};
    vecs[8]  = '{32'h0000_4000, 4'b1111, 32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0};
    vecs[9]  = '{32'h0000_0010, 4'b0000, 32'h0,          1'b0, 32'h1122_CCDD, 1'b0, 32'h0,          32'h0};
    vecs[10] = '{32'h0000_3FFC, 4'b1111, 32'hDEAD_BEEF,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_3FFC, 32'hDEAD_BEEF};
    vecs[11] = '{32'h0000_3FFC, 4'b0000, 32'h0,          1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,          32'h0};
    vecs[12] = '{32'h0000_0000, 4'b0100, 32'h0055_0000,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0055_0000};
    vecs[13] = '{32'h0000_0000, 4'b0000, 32'h0,          1'b0, 32'h0055_0000, 1'b0, 32'h0,          32'h0};

    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_byteen = 4'h0;
    req_wdata  = 32'h0;
    alt_valid  = 1'b0;
    alt_addr   = 32'h0;
    alt_byteen = 4'h0;
    alt_wdata  = 32'h0;
    reset      = 1'b1;

    // Outputs quiet while reset is held.
    repeat (3) step();
    checkOutput("reset_flags", {req_ready, resp_valid, resp_err, trace_valid}, 4'b0000);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    checkOutput("reset_trace", {trace_addr, trace_data}, 64'h0);

    // Reset in the middle of the INIT sweep must restart it from index 0.
    reset = 1'b0;
    repeat (100) step();
    checkOutput("init_ready_low", req_ready, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("post_reset_flags", {req_ready, resp_valid, resp_err, trace_valid}, 4'b0000);
    countReadyLow(n, saw);
    checkOutput("init_cycles", n, 4096);
    checkOutput("init_no_resp", saw, 1'b0);

    // Table of single transactions on the main instance.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].be, vecs[i].wdata, lat, err, rd, tv, ta, td);
      checkOutput($sformatf("v%0d_latency", i), lat, 2);
      checkOutput($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_trace_valid", i), tv, vecs[i].exp_trace);
      if (vecs[i].exp_trace) begin
        checkOutput($sformatf("v%0d_trace_addr", i), ta, vecs[i].exp_taddr);
        checkOutput($sformatf("v%0d_trace_data", i), td, vecs[i].exp_tdata);
      end
      step();
      checkOutput($sformatf("v%0d_resp_pulse", i), resp_valid, 1'b0);
    end

    // Back-to-back: write held valid, then a read of the same word accepted
    // in the write's response cycle returns the new data with no bubble.
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0020;
    req_byteen = 4'hF;
    req_wdata  = 32'h1234_5678;
    step();
    checkOutput("b2b_wait_ready", {req_ready, resp_valid}, 2'b00);
    checkOutput("b2b_trace", {trace_valid, trace_addr, trace_data}, {1'b1, 32'h20, 32'h1234_5678});
    step();
    checkOutput("b2b_resp1", {req_ready, resp_valid, resp_err}, 3'b110);
    req_byteen = 4'h0;
    req_wdata  = 32'h0;
    step();
    checkOutput("b2b_second_wait", {req_ready, resp_valid, trace_valid}, 3'b000);
    req_valid = 1'b0;
    step();
    checkOutput("b2b_resp2", {resp_valid, resp_err}, 2'b10);
    checkOutput("b2b_rdata", resp_rdata, 32'h1234_5678);

    // Reset during WAIT aborts the read and the sweep clears memory again.
    step();
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0010;
    req_byteen = 4'h0;
    step();
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    checkOutput("wait_reset_mask", {req_ready, resp_valid}, 2'b00);
    step();
    checkOutput("wait_reset_noresp1", resp_valid, 1'b0);
    step();
    checkOutput("wait_reset_noresp2", resp_valid, 1'b0);
    reset = 1'b0;
    countReadyLow(n, saw);
    checkOutput("resweep_cycles", n, 4096);
    checkOutput("resweep_no_resp", saw, 1'b0);
    applyStimulus(32'h0000_0010, 4'h0, 32'h0, lat, err, rd, tv, ta, td);
    checkOutput("cleared_latency", lat, 2);
    checkOutput("cleared_rdata", rd, 32'h0);
    step();

    // LATENCY 1 and 15 instances: write then read back, timing each.
    alt_valid  = 1'b1;
    alt_addr   = 32'h0000_0008;
    alt_byteen = 4'hF;
    alt_wdata  = 32'hCAFE_F00D;
    checkOutput("alt_ready", {a1_ready, a15_ready}, 2'b11);
    step();
    alt_valid = 1'b0;
    checkOutput("alt_trace", {a1_tvalid, a15_tvalid}, 2'b11);
    checkOutput("alt_trace_l1", {a1_taddr, a1_tdata}, {32'h8, 32'hCAFE_F00D});
    checkOutput("alt_trace_l15", {a15_taddr, a15_tdata}, {32'h8, 32'hCAFE_F00D});
    lat1  = -1;
    lat15 = -1;
    for (int k = 1; k <= 20; k++) begin
      if (a1_rvalid && lat1 < 0) lat1 = k;
      if (a15_rvalid && lat15 < 0) lat15 = k;
      step();
    end
    checkOutput("l1_write_latency", lat1, 1);
    checkOutput("l15_write_latency", lat15, 15);

    alt_valid  = 1'b1;
    alt_byteen = 4'h0;
    alt_wdata  = 32'h0;
    step();
    alt_valid = 1'b0;
    lat1  = -1;
    lat15 = -1;
    rd1   = 32'h0;
    rd15  = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      if (a1_rvalid && lat1 < 0) begin
        lat1 = k;
        rd1  = a1_rdata;
      end
      if (a15_rvalid && lat15 < 0) begin
        lat15 = k;
        rd15  = a15_rdata;
      end
      step();
    end
    checkOutput("l1_read_latency", lat1, 1);
    checkOutput("l15_read_latency", lat15, 15);
    checkOutput("l1_rdata", rd1, 32'hCAFE_F00D);
    checkOutput("l15_rdata", rd15, 32'hCAFE_F00D);
    checkOutput("alt_err", {a1_err, a15_err}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_lat.md
DATA_MEM_LAT -- requirements
Module: data_mem_lat

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width (multiple of 8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, log2 of memory depth in words.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from accept to response, legal range 1..15.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle if req_valid high.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_byteen  input  DATA_W/8  lane enables, all-zero = read, nonzero = write.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data, lane-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_W  read word, 0 for writes and errors.
REQ-014 SHALL have port resp_err  output  1  request rejected, valid with resp_valid.
REQ-015 SHALL have port trace_valid  output  1  one-cycle pulse per committed write.
REQ-016 SHALL have port trace_addr  output  32  word-aligned byte address of committed write.
REQ-017 SHALL have port trace_data  output  DATA_W  full merged word after the write.

Function
REQ-018 SHALL implement FSM states INIT, IDLE, WAIT, RESP.
REQ-019 INIT SHALL write 0 to one word per cycle, index 0..2^DEPTH_LOG2-1, then go to IDLE; req_ready low throughout.
REQ-020 req_ready SHALL be high exactly in IDLE and RESP.
REQ-021 Accept (req_valid & req_ready at an edge) SHALL move to WAIT if LATENCY>1, else to RESP.
REQ-022 WAIT SHALL count LATENCY-1 cycles, then go to RESP; resp_valid SHALL be high in the cycle beginning LATENCY edges after the accept edge (the accept edge counts as 1).
REQ-023 RESP without a new accept SHALL return to IDLE; with an accept SHALL behave as REQ-021 (back-to-back).
REQ-024 Error SHALL be flagged when addr not in [BASE_ADDR, BASE_ADDR + 2^DEPTH_LOG2*DATA_W/8) or addr low log2(DATA_W/8) bits nonzero.
REQ-025 A non-error write SHALL commit at the accept edge, updating only enabled lanes of word (addr-BASE_ADDR)/(DATA_W/8).
REQ-026 A non-error read SHALL sample the word at the accept edge and hold it in resp_rdata for the response cycle.
REQ-027 An error request SHALL not modify memory and SHALL return resp_rdata 0, resp_err 1.
REQ-028 trace_valid SHALL pulse the cycle after the commit edge, with trace_addr and trace_data of the committed word, independent of LATENCY.
REQ-029 A read accepted in RESP immediately after a write SHALL return the post-write data.
REQ-030 Inputs other than req_valid SHALL be ignored when no accept occurs.

Reset
REQ-031 Reset SHALL force state INIT with index 0, aborting any pending request without response.
REQ-032 During and one cycle after reset, req_ready, resp_valid, resp_err, trace_valid SHALL be 0; resp_rdata, trace_addr, trace_data SHALL be 0.
REQ-033 Reset asserted during INIT SHALL restart the sweep from index 0.

Structure
REQ-034 FSM state encoding and the lane-merge width constant SHALL live in shared package mem_pkg.
REQ-035 Latency counter SHALL be a sub-module lat_counter (load, count-down, done).

Verification
REQ-036 Reset released -> req_ready low for exactly 4096 cycles (default), then high; read of 0x10 -> rdata 0.
REQ-037 LATENCY=2: write 0x10 byteen 4'b0011 data 0xAABBCCDD, then read 0x10 -> trace_data 0x0000CCDD, resp_valid 2 cycles after each accept, rdata 0x0000CCDD.
REQ-038 Back-to-back: request held valid through RESP -> second accept in the resp cycle of the first, no idle bubble.
REQ-039 Read 0x4000 or 0x12 -> resp_err 1, rdata 0, no trace pulse, memory unchanged.
REQ-040 Reset asserted in WAIT -> no resp_valid, INIT sweep restarts, prior written word reads 0 afterwards.
REQ-041 LATENCY=1 and LATENCY=15 rebuilds -> response exactly 1 and 15 cycles after accept.
